// File: rtl/cond_pkg.sv
// Shared types and constants for the conditional-execution / ALU-decode stage.
// Condition codes, ALU commands and flag bit positions live here so both files agree.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
    MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
    HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
    GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
  } cond_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_ctrl_e;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Purely combinational condition evaluator: condition field x current flags -> execute.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v, ge;

  assign n  = flags[FLAG_N];
  assign z  = flags[FLAG_Z];
  assign c  = flags[FLAG_C];
  assign v  = flags[FLAG_V];
  assign ge = (n == v);

  always_comb begin
    cond_ex = 1'b0;
    case (cond_e'(cond))
      EQ: cond_ex = z;
      NE: cond_ex = ~z;
      CS: cond_ex = c;
      CC: cond_ex = ~c;
      MI: cond_ex = n;
      PL: cond_ex = ~n;
      VS: cond_ex = v;
      VC: cond_ex = ~v;
      HI: cond_ex = c & ~z;
      LS: cond_ex = ~c | z;
      GE: cond_ex = ge;
      LT: cond_ex = ~ge;
      GT: cond_ex = ~z & ge;
      LE: cond_ex = z | ~ge;
      AL: cond_ex = 1'b1;
      NV: cond_ex = 1'b0;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_control.sv
// Conditional-execution stage: decodes ALUControl, holds N/Z/C/V, and gates the
// main FSM's write requests with the condition result registered one cycle earlier.
module cond_control
  import cond_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  input  logic       ALUOp,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NextPC,
  input  logic       BranchS,
  output logic [1:0] ALUControl,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] Flags
);

  logic [3:0] cmd;
  logic [1:0] flag_w;
  logic [3:0] flags_q;
  logic       cond_ex;
  logic       cond_ex_reg;
  logic       pcs;
  logic       unused_bits;

  // Op and the immediate bit do not affect this stage.
  assign unused_bits = ^{Op, Funct[5]};

  assign cmd = Funct[4:1];

  always_comb begin
    ALUControl = ALU_ADD;
    if (ALUOp) begin
      case (cmd)
        CMD_ADD: ALUControl = ALU_ADD;
        CMD_SUB: ALUControl = ALU_SUB;
        CMD_AND: ALUControl = ALU_AND;
        CMD_ORR: ALUControl = ALU_ORR;
        default: ALUControl = ALU_ADD;
      endcase
    end
  end

  assign flag_w[1] = ALUOp & Funct[0];
  assign flag_w[0] = flag_w[1] & ((cmd == CMD_ADD) | (cmd == CMD_SUB));

  cond_check u_cond_check (
    .cond    (Cond),
    .flags   (flags_q),
    .cond_ex (cond_ex)
  );

  // Flag writes are gated by the unregistered condition so a skipped instruction leaves flags alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q[3:2] <= 2'b00;
    end else if (flag_w[1] & cond_ex) begin
      flags_q[3:2] <= ALUFlags[3:2];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q[1:0] <= 2'b00;
    end else if (flag_w[0] & cond_ex) begin
      flags_q[1:0] <= ALUFlags[1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cond_ex_reg <= 1'b0;
    end else begin
      cond_ex_reg <= cond_ex;
    end
  end

  assign pcs      = BranchS | (RegW & (Rd == 4'hF));
  assign PCWrite  = NextPC | (pcs & cond_ex_reg);
  assign RegWrite = RegW & cond_ex_reg;
  assign MemWrite = MemW & cond_ex_reg;
  assign Flags    = flags_q;

endmodule

// File: tb/tb_cond_control.sv
// Self-checking bench for cond_control: directed scenarios then randomized
// instructions, all compared against a behavioural model of the flag/condition rules.
module tb_cond_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] alu_flags;
  logic       alu_op;
  logic       reg_w;
  logic       mem_w;
  logic       next_pc;
  logic       branch_s;
  logic [1:0] alu_control;
  logic       pc_write;
  logic       reg_write;
  logic       mem_write;
  logic [3:0] flags;

  int checks   = 0;
  int failures = 0;

  // Model state: architectural flags {N,Z,C,V} and the condition result from last cycle.
  logic [3:0] m_flags;
  logic       m_cer;

  always #5 clk = ~clk;

  cond_control dut (
    .clk        (clk),
    .reset      (reset),
    .Cond       (cond),
    .Op         (op),
    .Funct      (funct),
    .Rd         (rd),
    .ALUFlags   (alu_flags),
    .ALUOp      (alu_op),
    .RegW       (reg_w),
    .MemW       (mem_w),
    .NextPC     (next_pc),
    .BranchS    (branch_s),
    .ALUControl (alu_control),
    .PCWrite    (pc_write),
    .RegWrite   (reg_write),
    .MemWrite   (mem_write),
    .Flags      (flags)
  );

  // Conditions come in pairs: an even code tests a predicate, the odd code its negation.
  function automatic logic model_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, r;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cy;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cy && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    return c[0] ? !r : r;
  endfunction

  function automatic logic [1:0] model_alu(input logic aop, input logic [3:0] cmd);
    if (!aop) return 2'd0;
    if (cmd == 4'd4)  return 2'd0;
    if (cmd == 4'd2)  return 2'd1;
    if (cmd == 4'd0)  return 2'd2;
    if (cmd == 4'd12) return 2'd3;
    return 2'd0;
  endfunction

  task automatic check_val(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    logic branching;
    branching = branch_s || (reg_w && rd == 4'd15);
    check_val("alu_control", {2'b00, alu_control}, {2'b00, model_alu(alu_op, funct[4:1])});
    check_val("pc_write",  {3'b000, pc_write},  {3'b000, next_pc || (branching && m_cer)});
    check_val("reg_write", {3'b000, reg_write}, {3'b000, reg_w && m_cer});
    check_val("mem_write", {3'b000, mem_write}, {3'b000, mem_w && m_cer});
    check_val("flags", flags, m_flags);
  endtask

  // Drive one cycle's inputs after the falling edge, check, then advance the model
  // to what the next rising edge should produce.
  task automatic apply_stimulus(input logic rst, input logic [3:0] c, input logic [5:0] fn,
                                input logic [3:0] d, input logic [3:0] af, input logic aop,
                                input logic rw, input logic mw, input logic np, input logic bs);
    logic ce;
    logic is_arith;
    @(negedge clk);
    reset = rst; cond = c; funct = fn; rd = d; alu_flags = af; alu_op = aop;
    reg_w = rw; mem_w = mw; next_pc = np; branch_s = bs; op = 2'($urandom_range(0, 3));
    if (rst) begin
      m_flags = 4'b0000;
      m_cer   = 1'b0;
    end
    #1;
    check_output();
    if (!rst) begin
      ce = model_cond(c, m_flags);
      is_arith = (fn[4:1] == 4'd4) || (fn[4:1] == 4'd2);
      if (aop && fn[0] && ce) begin
        m_flags[3:2] = af[3:2];
        if (is_arith) m_flags[1:0] = af[1:0];
      end
      m_cer = ce;
    end
  endtask

  initial begin
    m_flags = 4'b0000;
    m_cer   = 1'b0;
    reset = 1'b1; cond = 4'd0; op = 2'd0; funct = 6'd0; rd = 4'd0; alu_flags = 4'd0;
    alu_op = 1'b0; reg_w = 1'b0; mem_w = 1'b0; next_pc = 1'b0; branch_s = 1'b0;

    // Reset held with every write request raised.
    apply_stimulus(1, 4'b1110, 6'd0, 4'd0, 4'hF, 0, 1, 1, 1, 0);
    apply_stimulus(1, 4'b1110, 6'd0, 4'd0, 4'hF, 0, 1, 1, 1, 0);
    check_val("reset_flags", flags, 4'b0000);
    check_val("reset_reg_write", {3'b000, reg_write}, 4'd0);
    check_val("reset_mem_write", {3'b000, mem_write}, 4'd0);
    check_val("reset_pc_write", {3'b000, pc_write}, 4'd1);

    // SUBS setting Z and C, then an EQ instruction writes back a cycle later.
    apply_stimulus(0, 4'b1110, 6'b000101, 4'd1, 4'b0110, 1, 0, 0, 0, 0);
    check_val("subs_alu_control", {2'b00, alu_control}, 4'b0001);
    apply_stimulus(0, 4'b0000, 6'd0, 4'd1, 4'b0000, 0, 0, 0, 0, 0);
    check_val("subs_flags", flags, 4'b0110);
    apply_stimulus(0, 4'b0000, 6'd0, 4'd1, 4'b0000, 0, 1, 0, 0, 0);
    check_val("eq_reg_write", {3'b000, reg_write}, 4'd1);

    // ANDS updates only N,Z.
    apply_stimulus(0, 4'b1110, 6'b000001, 4'd2, 4'b1011, 1, 0, 0, 0, 0);
    apply_stimulus(0, 4'b1110, 6'd0, 4'd2, 4'b0000, 0, 0, 0, 0, 0);
    check_val("ands_flags", flags, 4'b1010);

    // Branch gated by EQ (not taken) then NE (taken) with Z=0.
    apply_stimulus(0, 4'b0000, 6'd0, 4'd0, 4'b0000, 0, 0, 0, 0, 0);
    apply_stimulus(0, 4'b0000, 6'd0, 4'd0, 4'b0000, 0, 0, 0, 0, 1);
    check_val("beq_pc_write", {3'b000, pc_write}, 4'd0);
    apply_stimulus(0, 4'b0001, 6'd0, 4'd0, 4'b0000, 0, 0, 0, 0, 0);
    apply_stimulus(0, 4'b0001, 6'd0, 4'd0, 4'b0000, 0, 0, 0, 0, 1);
    check_val("bne_pc_write", {3'b000, pc_write}, 4'd1);

    // Never-condition: setting ADDS is suppressed entirely.
    apply_stimulus(0, 4'b1111, 6'b001001, 4'd3, 4'b0101, 1, 1, 1, 0, 0);
    apply_stimulus(0, 4'b1111, 6'd0, 4'd3, 4'b0000, 0, 1, 1, 0, 0);
    check_val("nv_reg_write", {3'b000, reg_write}, 4'd0);
    check_val("nv_mem_write", {3'b000, mem_write}, 4'd0);
    check_val("nv_flags", flags, 4'b1010);

    // Write to R15 under AL acts as a branch; unknown cmd decodes to ADD.
    apply_stimulus(0, 4'b1110, 6'd0, 4'hF, 4'b0000, 0, 0, 0, 0, 0);
    apply_stimulus(0, 4'b1110, 6'd0, 4'hF, 4'b0000, 0, 1, 0, 0, 0);
    check_val("r15_reg_write", {3'b000, reg_write}, 4'd1);
    check_val("r15_pc_write", {3'b000, pc_write}, 4'd1);
    apply_stimulus(0, 4'b1110, 6'b001110, 4'd0, 4'b0000, 1, 0, 0, 0, 0);
    check_val("unknown_cmd_alu", {2'b00, alu_control}, 4'b0000);

    // Reset asserted mid-cycle kills pending gated writes immediately.
    apply_stimulus(0, 4'b1110, 6'd0, 4'd0, 4'b0000, 0, 1, 1, 0, 1);
    check_val("pre_reset_reg_write", {3'b000, reg_write}, 4'd1);
    #1;
    reset = 1'b1;
    m_flags = 4'b0000;
    m_cer   = 1'b0;
    #1;
    check_val("midreset_reg_write", {3'b000, reg_write}, 4'd0);
    check_val("midreset_mem_write", {3'b000, mem_write}, 4'd0);
    check_val("midreset_pc_write", {3'b000, pc_write}, 4'd0);
    check_val("midreset_flags", flags, 4'b0000);
    apply_stimulus(1, 4'b1110, 6'd0, 4'd0, 4'b0000, 0, 1, 1, 0, 1);

    // Randomized instruction stream.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] rc, rrd, raf;
      logic [5:0] rfn;
      rc  = 4'($urandom_range(0, 15));
      rfn = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 2) == 0) rfn[4:1] = ($urandom_range(0, 1) == 0) ? 4'd4 : 4'd2;
      rrd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      raf = 4'($urandom_range(0, 15));
      apply_stimulus(0, rc, rfn, rrd, raf, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cond_control.md
# cond_control

Conditional-execution and ALU-decode stage that sits between the multicycle main FSM and the datapath. Consumes the FSM's raw write/branch requests and ALUOp, decodes the ALU command, holds the architectural N/Z/C/V flags, evaluates the instruction's condition field, and produces the gated write enables (PCWrite, RegWrite, MemWrite) and ALUControl that the datapath actually uses.

## Interface
- No parameters. Widths are fixed by the ISA: 4-bit condition, 4-bit flags, 2-bit ALUControl.

Ports:
- clk  in  1  system clock, all state on posedge
- reset  in  1  asynchronous, active-high
- Cond  in  4  Instr[31:28]
- Op  in  2  Instr[27:26]
- Funct  in  6  Instr[25:20]: [5]=I, [4:1]=cmd, [0]=S
- Rd  in  4  Instr[15:12]
- ALUFlags  in  4  from ALU, {N,Z,C,V}
- ALUOp  in  1  from FSM: 1 = decode Funct, 0 = force ADD
- RegW  in  1  FSM register-write request
- MemW  in  1  FSM memory-write request
- NextPC  in  1  FSM unconditional PC update (Fetch)
- BranchS  in  1  FSM branch request
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- PCWrite  out  1  PC register enable
- RegWrite  out  1  register file write enable
- MemWrite  out  1  data memory write enable
- Flags  out  4  current flag register {N,Z,C,V}, for debug/observation

## Operation
- ALU decode (ALUOp=1): cmd 0100 -> ADD, 0010 -> SUB, 0000 -> AND, 1100 -> ORR; any other cmd -> ADD. ALUOp=0 -> ALUControl=00.
- FlagW[1] (N,Z) = ALUOp & Funct[0]. FlagW[0] (C,V) = ALUOp & Funct[0] & (cmd is ADD or SUB).
- Flag registers: NZ (Flags[3:2]) and CV (Flags[1:0]), separately enabled. Each loads ALUFlags slice on posedge when FlagW[i] & CondEx.
- CondEx (combinational, from Cond and registered Flags): EQ 0000 Z; NE ~Z; CS C; CC ~C; MI N; PL ~N; VS V; VC ~V; HI C&~Z; LS ~C|Z; GE N==V; LT N!=V; GT ~Z&(N==V); LE Z|(N!=V); AL 1110 -> 1; 1111 -> 0 (never).
- CondExReg: loaded with CondEx every cycle.
- PCS = BranchS | (RegW & Rd==4'hF).
- PCWrite = NextPC | (PCS & CondExReg); RegWrite = RegW & CondExReg; MemWrite = MemW & CondExReg.
- No internal FSM sequencing; sequencing is owned by the main FSM.

## Timing
- Reset (async): Flags=0000, CondExReg=0. Hence RegWrite=MemWrite=0 and PCWrite=NextPC during and immediately after reset.
- Condition evaluated in the Execute/MemAdr/Decode cycle; its gating takes effect one cycle later (ALUWB, MemWB, MemWrite, Branch states) via CondExReg.
- Flag update: same-cycle CondEx (unregistered) gates FlagWrite; new flags visible on Flags the cycle after the setting instruction's execute cycle.
- A flag write and a condition evaluation in the same cycle use the old flags (register read before update).
- Reset asserted mid-instruction: CondExReg clears immediately, suppressing any pending RegWrite/MemWrite/conditional PCWrite in that cycle.
- NextPC is never gated by condition.

## Structure
- Shared package cond_pkg: cond_e enum (EQ..AL, NV=1111), alu_ctrl_e (ADD/SUB/AND/ORR), cmd constants (CMD_ADD=4'b0100, CMD_SUB=4'b0010, CMD_AND=4'b0000, CMD_ORR=4'b1100), flag bit indices.
- One sub-module: cond_check (purely combinational Cond x Flags -> CondEx), instantiated once; registers live in cond_control.

## Test plan
- Reset held, NextPC=1, RegW=1, MemW=1 -> Flags=0000, RegWrite=0, MemWrite=0, PCWrite=1.
- SUBS (ALUOp=1, Funct=000101, Cond=1110), ALUFlags=0110 -> ALUControl=01; next cycle Flags=0110; Cond=0000 (EQ) then gives RegWrite=1 one cycle later with RegW=1.
- ANDS with ALUFlags=1011 after Flags=0110 -> Flags becomes 1010 (NZ updated, CV retained).
- Flags Z=0, Cond=0000, BranchS=1 in Branch cycle -> PCWrite=0; same with Cond=0001 -> PCWrite=1.
- Cond=1111, RegW=1, MemW=1, setting instruction -> RegWrite=0, MemWrite=0, flags unchanged.
- Rd=1111, RegW=1, Cond=1110 in ALUWB -> RegWrite=1 and PCWrite=1; unknown cmd 0111 with ALUOp=1 -> ALUControl=00.
